starsoc_pixel_gen: RTL and testbench
====================================

Name: starsoc_pixel_gen

Overview:
Downstream of the HDMI/VGA timing generator. Consumes pixel_x, pixel_y, hsync, vsync and video_on, and produces registered 12-bit RGB plus delay-matched syncs for the output encoder. Draws the StarSoC scene: scrolling starfield, player ship, one row of enemies and one bullet. Game-state inputs are latched once per frame at vsync rise, so each frame shows a stable snapshot of the game.

Parameters:
SPR_W, 16, sprite width in pixels (player and enemy)
SPR_H, 16, sprite height in pixels
N_ENEMY, 8, number of enemy slots in the row
ENEMY_X0, 64, x of enemy slot 0 (left edge)
ENEMY_PITCH, 64, x spacing between enemy slots
BUL_W, 2, bullet width
BUL_H, 8, bullet height
STAR_SPEED, 1, starfield rows scrolled per frame

Ports:
clk_100mhz  in  1  system clock
reset  in  1  asynchronous, active-high
pixel_x  in  10  current column from timing block
pixel_y  in  10  current row from timing block
hsync_in  in  1  hsync from timing block
vsync_in  in  1  vsync from timing block
video_on  in  1  visible-area flag
player_x  in  10  player left edge
player_y  in  10  player top edge
enemy_y  in  10  enemy row top edge
enemy_alive  in  N_ENEMY  per-slot alive mask
bullet_x  in  10  bullet left edge
bullet_y  in  10  bullet top edge
bullet_active  in  1  bullet visible
rgb  out  12  {R[3:0],G[3:0],B[3:0]}
hsync_out  out  1  hsync delayed to match rgb
vsync_out  out  1  vsync delayed to match rgb
de_out  out  1  video_on delayed to match rgb
frame_cnt  out  8  frames since reset, wraps 255->0

Behaviour:
- Everything runs on clk_100mhz; no pixel-clock domain inside this block.
- Reset values: rgb=0, hsync_out=0, vsync_out=0, de_out=0, frame_cnt=0, scroll=0, vsync_d=0.
- Reset values of the active game registers: player (312,440), enemy_y=32, enemy_alive=0, bullet inactive, bullet x/y=0.
- Reset asserted mid-frame clears all state immediately. The first frame_start after release latches the game inputs.
- frame_start = vsync_in & ~vsync_d (vsync_d is a 1-cycle registered copy of vsync_in).
- On frame_start:
  - Latch all game inputs into the active registers; the value present on that cycle is captured.
  - frame_cnt += 1, wrapping modulo 256.
  - scroll += STAR_SPEED, wrapping modulo 1024 (10-bit).
- Game-input changes between frame_starts have no visible effect until the next frame_start.
- Pipeline, 2 clk_100mhz cycles total; pixel_x/y/video_on at cycle N produce rgb/de_out at cycle N+2.
  - Stage 1 registers the hit flags: bul_hit, ply_hit, enemy_hit, star_hit, plus video_on, hsync_in and vsync_in.
  - Stage 2 registers the priority-muxed colour and the sync/de outputs.
- Hit test: px >= X and px < X+W, same form for y. Compare at 11 bits so X+W never wraps; a sprite at x=630 shows columns 630..639 only.
- Enemy slot i: x = ENEMY_X0 + i*ENEMY_PITCH, computed as constants. Hit only if enemy_alive[i]. enemy_hit is the OR over all slots.
- Bullet hit only when bullet_active.
- Star: sy = pixel_y + scroll (10-bit wrap). Star when pixel_x[2:0]==0, sy[2:0]==0, and (pixel_x[8:3] ^ sy[8:3])[2:0]==3'b101.
- Colour priority:
  1. de=0 -> 12'h000
  2. bullet -> 12'hFF0
  3. player -> 12'hFFF
  4. enemy -> 12'hF00
  5. star -> 12'h888
  6. otherwise 12'h000
- Sync polarity passes through unchanged.

Decomposition:
- starsoc_params package holds: colour constants (COL_BG, COL_STAR, COL_PLAYER, COL_ENEMY, COL_BULLET), the reset positions (PLY_X_RST, PLY_Y_RST, ENEMY_Y_RST), and the existing h_max/v_max timing constants.
- Package typedef: rgb12_t, a 12-bit logic vector.
- One sub-module: starsoc_rect_hit. Parameters W/H; inputs px, py, x, y, en; output 1-bit hit. Instantiated for the player, the bullet and each enemy slot.

Test Plan:
- Reset mid-frame: assert reset during line 100 -> rgb, hsync_out, vsync_out, de_out and frame_cnt all 0 on the same cycle. After release, player is drawn at (312,440) until the first frame_start.
- Latency: drive pixel (312,440) with video_on=1 and defaults -> rgb=12'hFFF exactly 2 cycles later. hsync_out/vsync_out equal hsync_in/vsync_in delayed by 2.
- Frame latching: change player_x from 312 to 100 mid-frame -> pixel (100,440) stays 12'h000 for the rest of the frame and reads 12'hFFF after the next vsync rise. frame_cnt increments by exactly 1 per vsync rise and wraps from 255 to 0.
- Priority overlap: bullet at (320,445) active with player at (312,440) -> pixel (320,445) = 12'hFF0. With bullet_active=0 the same pixel = 12'hFFF.
- Enemy mask: enemy_alive=8'b0000_0100, enemy_y=32 -> pixel (192,40) = 12'hF00; pixel (64,40) = 12'h000 (no star there).
- Edge and starfield:
  - player_x=630 -> pixel 639 is white, no wrap artefact at column 0.
  - With scroll=0, pixel (40,0) is a star (12'h888).
  - After 8 frames with STAR_SPEED=1, that star appears at (40,1016-wrap equivalent).
  - video_on=0 forces 12'h000 regardless of any hit.

Source files
------------

// File: rtl/starsoc_params_pkg.sv
// Shared constants and types for the StarSoC video pipeline.
package starsoc_params;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned H_MAX   = 800;
  localparam int unsigned V_MAX   = 525;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t COL_BG     = 12'h000;
  localparam rgb12_t COL_STAR   = 12'h888;
  localparam rgb12_t COL_PLAYER = 12'hFFF;
  localparam rgb12_t COL_ENEMY  = 12'hF00;
  localparam rgb12_t COL_BULLET = 12'hFF0;

  localparam logic [COORD_W-1:0] PLY_X_RST   = 10'd312;
  localparam logic [COORD_W-1:0] PLY_Y_RST   = 10'd440;
  localparam logic [COORD_W-1:0] ENEMY_Y_RST = 10'd32;

endpackage

// File: rtl/starsoc_rect_hit.sv
// Axis-aligned rectangle hit test; 11-bit bounds so x+W never wraps.
module starsoc_rect_hit
  import starsoc_params::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned H = 16
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               en,
  output logic               hit
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, x} + (COORD_W+1)'(W);
  assign y_end = {1'b0, y} + (COORD_W+1)'(H);

  assign hit = en
             & (px >= x) & ({1'b0, px} < x_end)
             & (py >= y) & ({1'b0, py} < y_end);

endmodule

// File: rtl/starsoc_pixel_gen.sv
// StarSoC scene renderer: frame-latched game state, 2-stage hit/colour pipeline.
module starsoc_pixel_gen
  import starsoc_params::*;
#(
  parameter int unsigned SPR_W       = 16,
  parameter int unsigned SPR_H       = 16,
  parameter int unsigned N_ENEMY     = 8,
  parameter int unsigned ENEMY_X0    = 64,
  parameter int unsigned ENEMY_PITCH = 64,
  parameter int unsigned BUL_W       = 2,
  parameter int unsigned BUL_H       = 8,
  parameter int unsigned STAR_SPEED  = 1
) (
  input  logic               clk_100mhz,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               video_on,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] enemy_y,
  input  logic [N_ENEMY-1:0] enemy_alive,
  input  logic [COORD_W-1:0] bullet_x,
  input  logic [COORD_W-1:0] bullet_y,
  input  logic               bullet_active,
  output rgb12_t             rgb,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out,
  output logic [7:0]         frame_cnt
);

  logic                vsync_d;
  logic                frame_start;
  logic [COORD_W-1:0]  scroll;
  logic [COORD_W-1:0]  act_px, act_py, act_ey, act_bx, act_by;
  logic [N_ENEMY-1:0]  act_alive;
  logic                act_ba;

  assign frame_start = vsync_in & ~vsync_d;

  // Game snapshot and frame counters update once per frame
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      vsync_d   <= 1'b0;
      frame_cnt <= '0;
      scroll    <= '0;
      act_px    <= PLY_X_RST;
      act_py    <= PLY_Y_RST;
      act_ey    <= ENEMY_Y_RST;
      act_alive <= '0;
      act_ba    <= 1'b0;
      act_bx    <= '0;
      act_by    <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
        scroll    <= scroll + COORD_W'(STAR_SPEED);
        act_px    <= player_x;
        act_py    <= player_y;
        act_ey    <= enemy_y;
        act_alive <= enemy_alive;
        act_ba    <= bullet_active;
        act_bx    <= bullet_x;
        act_by    <= bullet_y;
      end
    end
  end

  logic               ply_hit_c, bul_hit_c, enemy_hit_c, star_hit_c;
  logic [N_ENEMY-1:0] enemy_hits_c;
  logic [5:0]         sy_lo_c;

  starsoc_rect_hit #(.W(SPR_W), .H(SPR_H)) u_player (
    .px(pixel_x), .py(pixel_y), .x(act_px), .y(act_py), .en(1'b1), .hit(ply_hit_c)
  );

  starsoc_rect_hit #(.W(BUL_W), .H(BUL_H)) u_bullet (
    .px(pixel_x), .py(pixel_y), .x(act_bx), .y(act_by), .en(act_ba), .hit(bul_hit_c)
  );

  for (genvar i = 0; i < int'(N_ENEMY); i++) begin : g_enemy
    localparam logic [COORD_W-1:0] EX = COORD_W'(ENEMY_X0 + i * ENEMY_PITCH);
    starsoc_rect_hit #(.W(SPR_W), .H(SPR_H)) u_enemy (
      .px(pixel_x), .py(pixel_y), .x(EX), .y(act_ey), .en(act_alive[i]),
      .hit(enemy_hits_c[i])
    );
  end

  assign enemy_hit_c = |enemy_hits_c;

  // Only the low 6 bits of the scrolled row feed the star pattern
  assign sy_lo_c    = pixel_y[5:0] + scroll[5:0];
  assign star_hit_c = (pixel_x[2:0] == 3'd0) && (sy_lo_c[2:0] == 3'd0)
                   && ((pixel_x[5:3] ^ sy_lo_c[5:3]) == 3'b101);

  logic bul_hit, ply_hit, enemy_hit, star_hit, de_s1, hs_s1, vs_s1;

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      bul_hit   <= 1'b0;
      ply_hit   <= 1'b0;
      enemy_hit <= 1'b0;
      star_hit  <= 1'b0;
      de_s1     <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
    end else begin
      bul_hit   <= bul_hit_c;
      ply_hit   <= ply_hit_c;
      enemy_hit <= enemy_hit_c;
      star_hit  <= star_hit_c;
      de_s1     <= video_on;
      hs_s1     <= hsync_in;
      vs_s1     <= vsync_in;
    end
  end

  rgb12_t colour_c;

  always_comb begin
    colour_c = COL_BG;
    if (!de_s1)        colour_c = COL_BG;
    else if (bul_hit)  colour_c = COL_BULLET;
    else if (ply_hit)  colour_c = COL_PLAYER;
    else if (enemy_hit) colour_c = COL_ENEMY;
    else if (star_hit) colour_c = COL_STAR;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      rgb       <= COL_BG;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      rgb       <= colour_c;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      de_out    <= de_s1;
    end
  end

endmodule

// File: tb/tb_starsoc_pixel_gen.sv
// Scoreboard bench for starsoc_pixel_gen: expected pixels queued at drive time, checked 2 cycles later.
module tb_starsoc_pixel_gen;

  logic        clk_100mhz = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        hsync_in, vsync_in, video_on;
  logic [9:0]  player_x, player_y, enemy_y, bullet_x, bullet_y;
  logic [7:0]  enemy_alive;
  logic        bullet_active;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, de_out;
  logic [7:0]  frame_cnt;

  always #5 clk_100mhz = ~clk_100mhz;

  starsoc_pixel_gen dut (
    .clk_100mhz(clk_100mhz), .reset(reset),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on(video_on),
    .player_x(player_x), .player_y(player_y), .enemy_y(enemy_y),
    .enemy_alive(enemy_alive), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [11:0] rgb;
    logic [2:0]  syn;
    logic [63:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Bench's own picture of the latched game state
  int         act_px, act_py, act_ey, act_bx, act_by;
  logic [7:0] act_alive;
  logic       act_ba;
  int         m_scroll, m_frame;
  logic       prev_vs;

  task automatic check_val(input logic [63:0] tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rect(int x, int y, int rx, int ry, int w, int h);
    return (x >= rx) && (x < rx + w) && (y >= ry) && (y < ry + h);
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, logic de);
    int sy;
    if (!de) return 12'h000;
    if (act_ba && in_rect(x, y, act_bx, act_by, 2, 8)) return 12'hFF0;
    if (in_rect(x, y, act_px, act_py, 16, 16)) return 12'hFFF;
    for (int i = 0; i < 8; i++)
      if (act_alive[i] && in_rect(x, y, 64 + 64 * i, act_ey, 16, 16)) return 12'hF00;
    sy = (y + m_scroll) % 1024;
    if ((x % 8 == 0) && (sy % 8 == 0) && ((((x / 8) ^ (sy / 8)) % 8) == 5)) return 12'h888;
    return 12'h000;
  endfunction

  task automatic model_reset();
    act_px = 312; act_py = 440; act_ey = 32; act_alive = '0;
    act_ba = 1'b0; act_bx = 0; act_by = 0;
    m_scroll = 0; m_frame = 0; prev_vs = 1'b0;
  endtask

  task automatic apply(input int x, input int y, input logic de, input logic hs,
                       input logic vs, input logic [63:0] tag, input logic use_c,
                       input logic [11:0] c);
    exp_t e, g;
    pixel_x = 10'(x); pixel_y = 10'(y);
    video_on = de; hsync_in = hs; vsync_in = vs;
    e.rgb = use_c ? c : model_rgb(x, y, de);
    e.syn = {hs, vs, de};
    e.tag = tag;
    q.push_back(e);
    if (vs && !prev_vs) begin
      act_px = int'(player_x); act_py = int'(player_y); act_ey = int'(enemy_y);
      act_alive = enemy_alive; act_ba = bullet_active;
      act_bx = int'(bullet_x); act_by = int'(bullet_y);
      m_frame = (m_frame + 1) % 256;
      m_scroll = (m_scroll + 1) % 1024;
    end
    prev_vs = vs;
    @(posedge clk_100mhz); #1;
    while (q.size() >= 2) begin
      g = q.pop_front();
      check_val(g.tag, 32'(rgb), 32'(g.rgb));
      check_val("sync_de", 32'({hsync_out, vsync_out, de_out}), 32'(g.syn));
    end
  endtask

  task automatic pix(input int x, input int y, input logic [63:0] tag);
    apply(x, y, 1'b1, 1'($urandom_range(0, 1)), 1'b0, tag, 1'b0, 12'h000);
  endtask

  task automatic pixc(input int x, input int y, input logic de,
                      input logic [63:0] tag, input logic [11:0] c);
    apply(x, y, de, 1'($urandom_range(0, 1)), 1'b0, tag, 1'b1, c);
  endtask

  task automatic frame();
    apply(0, 480, 1'b0, 1'b0, 1'b1, "vs_rise", 1'b0, 12'h000);
    apply(0, 481, 1'b0, 1'b1, 1'b1, "vs_hold", 1'b0, 12'h000);
    apply(0, 482, 1'b0, 1'b0, 1'b0, "vs_fall", 1'b0, 12'h000);
  endtask

  task automatic check_reset_outputs(input logic [63:0] tag);
    check_val(tag, 32'({rgb, hsync_out, vsync_out, de_out, frame_cnt}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    pixel_x = '0; pixel_y = '0; hsync_in = 1'b0; vsync_in = 1'b0; video_on = 1'b0;
    player_x = 10'd312; player_y = 10'd440; enemy_y = 10'd32; enemy_alive = '0;
    bullet_x = '0; bullet_y = '0; bullet_active = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst_init");
    @(posedge clk_100mhz); #1;
    reset = 1'b0;

    pixc(312, 440, 1'b1, "lat_ply", 12'hFFF);
    pixc(327, 455, 1'b1, "ply_br", 12'hFFF);
    pixc(328, 440, 1'b1, "ply_xo", 12'h000);
    pixc(40, 0, 1'b1, "star0", 12'h888);
    pix(48, 0, "nostar");

    // Mid-frame input change is invisible until the next vsync rise
    player_x = 10'd100;
    pixc(100, 440, 1'b1, "lat_old", 12'h000);
    pixc(312, 440, 1'b1, "lat_keep", 12'hFFF);
    frame();
    check_val("frm1", 32'(frame_cnt), 32'd1);
    pixc(100, 440, 1'b1, "lat_new", 12'hFFF);
    pixc(312, 440, 1'b1, "lat_gone", 12'h000);

    player_x = 10'd312;
    bullet_x = 10'd320; bullet_y = 10'd445; bullet_active = 1'b1;
    frame();
    check_val("frm2", 32'(frame_cnt), 32'd2);
    pixc(320, 445, 1'b1, "pri_bul", 12'hFF0);
    pixc(321, 452, 1'b1, "bul_br", 12'hFF0);
    pixc(322, 445, 1'b1, "bul_xo", 12'hFFF);
    bullet_active = 1'b0;
    frame();
    pixc(320, 445, 1'b1, "pri_ply", 12'hFFF);

    enemy_alive = 8'b0000_0100;
    frame();
    pixc(192, 40, 1'b1, "enemy2", 12'hF00);
    pix(64, 40, "enemy0");
    pix(256, 40, "enemy3");
    pixc(207, 47, 1'b1, "enm_br", 12'hF00);
    enemy_alive = 8'b1000_0001;
    pixc(192, 40, 1'b1, "enm_lat", 12'hF00);
    frame();
    pixc(64, 40, 1'b1, "enemy0b", 12'hF00);
    pixc(512, 32, 1'b1, "enemy7", 12'hF00);
    pix(192, 40, "enemy2b");
    pixc(320, 445, 1'b1, "pri_enm", 12'hFFF);

    player_x = 10'd630;
    frame();
    pixc(639, 440, 1'b1, "edge639", 12'hFFF);
    pixc(630, 455, 1'b1, "edge630", 12'hFFF);
    pix(0, 440, "edge0");
    pix(4, 445, "edge4");
    pixc(639, 440, 1'b0, "de_off", 12'h000);

    // Reset in the middle of line 100
    for (int i = 0; i < 4; i++) pix(200 + i, 100, "line100");
    vsync_in = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    q.delete();
    model_reset();
    @(posedge clk_100mhz); @(posedge clk_100mhz); #1;
    reset = 1'b0;
    pixc(312, 440, 1'b1, "rst_ply", 12'hFFF);
    pixc(639, 440, 1'b1, "rst_noin", 12'h000);
    pixc(40, 0, 1'b1, "star_s0", 12'h888);

    player_x = 10'd312;
    for (int f = 0; f < 8; f++) frame();
    check_val("frm8", 32'(frame_cnt), 32'd8);
    pixc(40, 1016, 1'b1, "star_s8", 12'h888);
    pix(40, 0, "star_mv");
    pix(40, 504, "star_504");

    while (m_frame != 255) begin
      apply(0, 480, 1'b0, 1'b0, 1'b1, "vs_rise", 1'b0, 12'h000);
      apply(0, 481, 1'b0, 1'b0, 1'b0, "vs_fall", 1'b0, 12'h000);
    end
    check_val("cnt255", 32'(frame_cnt), 32'd255);
    frame();
    check_val("cnt_wrap", 32'(frame_cnt), 32'd0);
    pix(40, 0, "star_end");
    pix(312, 440, "ply_end");

    pixc(0, 0, 1'b0, "drain", 12'h000);
    pixc(0, 0, 1'b0, "drain", 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
